// File: rtl/ccd_dvp_capture.sv
// Purpose : capture the AFE parallel port, crop a programmable window and emit a framed pixel stream.
// Latency : dvp pins -> FIFO write 2 cycles; FIFO write -> m_valid 1 cycle when the FIFO was empty.
// Backpressure: valid/ready on the m_* side; window pixels arriving while the FIFO is full are dropped
//               and flagged in sts_overflow (the sensor cannot be stalled).
//
// Ports:
//   clk, rst                  AFE pixel clock, synchronous active-high reset
//   dvp_hsync_n/vsync_n/data  AFE parallel output (syncs active low)
//   cfg_en, cfg_h_*, cfg_v_*  capture enable and crop window, shadowed at frame start
//   m_valid/m_ready/m_data    output stream, with m_sof (first pixel of frame) and m_eol (last pixel of line)
//   frame_done, frame_cnt     completed-window pulse and wrapping frame counter
//   sts_overflow, sts_short   sticky status, cleared by sts_clr (a same-cycle set wins)
`timescale 1ns/1ps

// Purpose : small synchronous FIFO with first-word-fall-through read.
// Latency : write -> o_valid 1 cycle.
// Backpressure: o_full reports occupancy; the caller may push while full only when popping the same cycle.
module ccd_dvp_capture_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_dat,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_do_pop;

  assign o_valid  = (r_cnt != '0);
  assign o_full   = (r_cnt == (AW+1)'(DEPTH));
  // Zero when empty so the output bus reads 0 out of reset.
  assign o_dat    = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_do_pop = i_pop & o_valid;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({i_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module ccd_dvp_capture #(
  parameter int DW         = 14,
  parameter int CNTW       = 15,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dvp_hsync_n,
  input  logic            dvp_vsync_n,
  input  logic [DW-1:0]   dvp_data,
  input  logic            cfg_en,
  input  logic [CNTW-1:0] cfg_h_start,
  input  logic [CNTW-1:0] cfg_h_count,
  input  logic [CNTW-1:0] cfg_v_start,
  input  logic [CNTW-1:0] cfg_v_count,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_sof,
  output logic            m_eol,
  output logic            frame_done,
  output logic [15:0]     frame_cnt,
  output logic            sts_overflow,
  output logic            sts_short,
  input  logic            sts_clr
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [CNTW:0] ONE_X = (CNTW+1)'(1);

  // Input stage: S1 samples the pins, the second rank only feeds edge detection.
  logic          r_hs1, r_vs1, r_hs2, r_vs2;
  logic [DW-1:0] r_d1;
  logic          w_fs, w_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
      r_d1  <= '0;
    end else begin
      r_hs1 <= dvp_hsync_n;
      r_vs1 <= dvp_vsync_n;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_d1  <= dvp_data;
    end
  end

  assign w_fs = r_vs2 & ~r_vs1;
  assign w_ls = r_hs2 & ~r_hs1;

  // Column/line counters. r_col is the index of the pixel currently in S1:
  // it is zeroed during blanking and advances after each active pixel.
  logic [CNTW-1:0] r_col, r_line;
  logic            r_first_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_line     <= '0;
      r_first_ls <= 1'b0;
    end else begin
      if (w_ls) begin
        r_col <= '0;
      end else if (r_hs1 && !(&r_col)) begin
        r_col <= r_col + CNTW'(1);
      end

      // The first LS of a frame (or one coinciding with FS) is line 0.
      if (w_fs) begin
        r_line     <= '0;
        r_first_ls <= ~w_ls;
      end else if (w_ls) begin
        if (r_first_ls) begin
          r_line     <= '0;
          r_first_ls <= 1'b0;
        end else if (!(&r_line)) begin
          r_line <= r_line + CNTW'(1);
        end
      end
    end
  end

  // Window shadows, reloaded only at frame start.
  logic [CNTW-1:0] r_h_start, r_h_count, r_v_start, r_v_count;
  logic            w_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_start <= '0;
      r_h_count <= '0;
      r_v_start <= '0;
      r_v_count <= '0;
    end else if (w_load) begin
      r_h_start <= cfg_h_start;
      r_h_count <= cfg_h_count;
      r_v_start <= cfg_v_start;
      r_v_count <= cfg_v_count;
    end
  end

  // Window ends computed one bit wider so start+count never wraps.
  // A zero count gives an empty range, so the FSM simply waits for the next FS.
  logic [CNTW:0] w_h_end, w_v_end;
  logic          w_in_h, w_in_v, w_pix, w_last_col, w_last_line;

  assign w_h_end     = {1'b0, r_h_start} + {1'b0, r_h_count};
  assign w_v_end     = {1'b0, r_v_start} + {1'b0, r_v_count};
  assign w_in_h      = (r_col >= r_h_start) && ({1'b0, r_col} < w_h_end);
  assign w_in_v      = (r_line >= r_v_start) && ({1'b0, r_line} < w_v_end);
  assign w_pix       = r_hs1 & w_in_h & w_in_v;
  assign w_last_col  = ({1'b0, r_col} == (w_h_end - ONE_X));
  assign w_last_line = ({1'b0, r_line} == (w_v_end - ONE_X));

  // Capture FSM.
  state_t r_state, w_state_nxt;
  logic   w_push_req, w_sof, w_eol, w_done, w_short_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    w_sof       = 1'b0;
    w_eol       = 1'b0;
    w_done      = 1'b0;
    w_short_set = 1'b0;
    w_load      = 1'b0;
    if (w_fs) begin
      // A new frame always restarts from the IDLE decision, abandoning any open window.
      w_load      = 1'b1;
      w_short_set = (r_state != S_IDLE);
      w_state_nxt = cfg_en ? S_ARMED : S_IDLE;
    end else begin
      case (r_state)
        S_ARMED, S_CAPTURE: begin
          if (w_pix) begin
            w_push_req = 1'b1;
            w_sof      = (r_state == S_ARMED);
            w_eol      = w_last_col;
            if (w_last_col && w_last_line) begin
              w_done      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_CAPTURE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output FIFO. Pushing while full is allowed when the head leaves in the same cycle.
  logic          w_fifo_full, w_pop, w_can_push, w_push, w_ovf_set;
  logic [DW+1:0] w_fifo_out;

  assign w_pop      = m_valid & m_ready;
  assign w_can_push = ~w_fifo_full | w_pop;
  assign w_push     = w_push_req & w_can_push;
  assign w_ovf_set  = w_push_req & ~w_can_push;

  ccd_dvp_capture_fifo #(
    .W     (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat ({w_sof, w_eol, r_d1}),
    .i_pop      (w_pop),
    .o_valid    (m_valid),
    .o_dat      (w_fifo_out),
    .o_full     (w_fifo_full)
  );

  assign m_sof  = w_fifo_out[DW+1];
  assign m_eol  = w_fifo_out[DW];
  assign m_data = w_fifo_out[DW-1:0];

  // Frame completion follows the window even if the final pixel was dropped.
  logic        r_frame_done, r_sts_overflow, r_sts_short;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done   <= 1'b0;
      r_frame_cnt    <= '0;
      r_sts_overflow <= 1'b0;
      r_sts_short    <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_ovf_set) begin
        r_sts_overflow <= 1'b1;
      end else if (sts_clr) begin
        r_sts_overflow <= 1'b0;
      end
      if (w_short_set) begin
        r_sts_short <= 1'b1;
      end else if (sts_clr) begin
        r_sts_short <= 1'b0;
      end
    end
  end

  assign frame_done   = r_frame_done;
  assign frame_cnt    = r_frame_cnt;
  assign sts_overflow = r_sts_overflow;
  assign sts_short    = r_sts_short;
endmodule

// File: tb/tb_ccd_dvp_capture.sv
`timescale 1ns/1ps
module tb_ccd_dvp_capture;
  localparam int DW   = 14;
  localparam int CNTW = 15;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            dvp_hsync_n, dvp_vsync_n;
  logic [DW-1:0]   dvp_data;
  logic            cfg_en;
  logic [CNTW-1:0] cfg_h_start, cfg_h_count, cfg_v_start, cfg_v_count;
  logic            m_valid, m_ready;
  logic [DW-1:0]   m_data;
  logic            m_sof, m_eol;
  logic            frame_done;
  logic [15:0]     frame_cnt;
  logic            sts_overflow, sts_short, sts_clr;

  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clk = ~clk;

  ccd_dvp_capture #(.DW(DW), .CNTW(CNTW), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .dvp_hsync_n  (dvp_hsync_n),
    .dvp_vsync_n  (dvp_vsync_n),
    .dvp_data     (dvp_data),
    .cfg_en       (cfg_en),
    .cfg_h_start  (cfg_h_start),
    .cfg_h_count  (cfg_h_count),
    .cfg_v_start  (cfg_v_start),
    .cfg_v_count  (cfg_v_count),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sof        (m_sof),
    .m_eol        (m_eol),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .sts_overflow (sts_overflow),
    .sts_short    (sts_short),
    .sts_clr      (sts_clr)
  );

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got data=%h sof=%b eol=%b, wanted no beat", m_data, m_sof, m_eol);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_data, m_sof, m_eol} !== {mon_e.d, mon_e.sof, mon_e.eol}) begin
          bad++;
          $display("FAIL beat: got data=%h sof=%b eol=%b, want data=%h sof=%b eol=%b",
                   m_data, m_sof, m_eol, mon_e.d, mon_e.sof, mon_e.eol);
        end
      end
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Expected run of consecutive pixel values.
  task automatic exp_run(input int base, input int n, input bit sof1, input bit eol_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d   = DW'(base + k);
      b.sof = sof1 && (k == 0);
      b.eol = eol_last && (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // Each line: 2 blanking cycles (hsync low), then px pixels with data = col + 16*line.
  // VSYNC falls together with the first line's HSYNC.
  task automatic send_frame(input int nlines, input int px);
    for (int l = 0; l < nlines; l++) begin
      for (int b = 0; b < 2; b++) begin
        tick();
        dvp_hsync_n = 1'b0;
        dvp_vsync_n = (l == 0) ? 1'b0 : 1'b1;
        dvp_data    = '0;
      end
      for (int c = 0; c < px; c++) begin
        tick();
        dvp_hsync_n = 1'b1;
        dvp_vsync_n = 1'b1;
        dvp_data    = DW'(c + 16 * l);
      end
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      dvp_data = '0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic set_win(input int hs, input int hc, input int vs, input int vc);
    cfg_h_start = CNTW'(hs);
    cfg_h_count = CNTW'(hc);
    cfg_v_start = CNTW'(vs);
    cfg_v_count = CNTW'(vc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dvp_hsync_n = 1'b1; dvp_vsync_n = 1'b1; dvp_data = '0;
    cfg_en = 1'b1; m_ready = 1'b1; sts_clr = 1'b0;
    set_win(2, 4, 1, 2);
    repeat (3) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_sof_eol", {m_sof, m_eol}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_sticky", {sts_overflow, sts_short}, 0);
    rst = 1'b0;
    repeat (3) tick();

    // Basic 4x2 window.
    exp_run(16'h12, 4, 1, 1);
    exp_run(16'h22, 4, 0, 1);
    send_frame(4, 10);
    wait_drain();
    check("basic_frame_cnt", frame_cnt, 1);
    check("basic_done_cnt", done_cnt, 1);

    // Capture disabled at FS.
    cfg_en = 1'b0;
    send_frame(4, 10);
    cfg_en = 1'b1;
    wait_drain();
    check("dis_frame_cnt", frame_cnt, 1);
    check("dis_done_cnt", done_cnt, 1);

    // Mid-frame config change takes effect on the following frame.
    exp_run(16'h12, 4, 1, 1);
    exp_run(16'h22, 4, 0, 1);
    fork
      send_frame(4, 10);
      begin
        repeat (20) @(posedge clk);
        #1;
        cfg_h_start = '0;
      end
    join
    exp_run(16'h10, 4, 1, 1);
    exp_run(16'h20, 4, 0, 1);
    send_frame(4, 10);
    wait_drain();
    check("chg_frame_cnt", frame_cnt, 3);
    check("chg_done_cnt", done_cnt, 3);

    // Overflow: 20-pixel window into a 16-entry FIFO with the sink stalled.
    set_win(0, 10, 0, 2);
    m_ready = 1'b0;
    send_frame(4, 10);
    check("ovf_flag", sts_overflow, 1);
    check("ovf_stall_valid", m_valid, 1);
    check("ovf_stall_head", {m_data, m_sof, m_eol}, {14'h00, 1'b1, 1'b0});
    check("ovf_frame_cnt", frame_cnt, 4);
    check("ovf_done_cnt", done_cnt, 4);
    exp_run(16'h00, 10, 1, 1);
    exp_run(16'h10, 6, 0, 0);
    m_ready = 1'b1;
    wait_drain();
    check("ovf_flag_held", sts_overflow, 1);
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    check("ovf_flag_clr", sts_overflow, 0);
    check("short_pre", sts_short, 0);

    // Short frame: VSYNC after only the first window line.
    set_win(2, 4, 1, 2);
    exp_run(16'h12, 4, 1, 1);
    send_frame(2, 10);
    exp_run(16'h12, 4, 1, 1);
    exp_run(16'h22, 4, 0, 1);
    send_frame(4, 10);
    wait_drain();
    check("short_flag", sts_short, 1);
    check("short_done_cnt", done_cnt, 5);
    check("short_frame_cnt", frame_cnt, 5);
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    check("short_clr", sts_short, 0);

    // Reset mid-line while beats are held in the FIFO.
    m_ready = 1'b0;
    fork
      send_frame(4, 10);
      begin
        repeat (19) @(posedge clk);
        #1;
        check("rstmid_valid_before", m_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_valid_after", m_valid, 0);
        m_ready = 1'b1;
      end
    join
    wait_drain();
    check("rstmid_frame_cnt", frame_cnt, 0);
    check("rstmid_done_cnt", done_cnt, 5);
    exp_run(16'h12, 4, 1, 1);
    exp_run(16'h22, 4, 0, 1);
    send_frame(4, 10);
    wait_drain();
    check("post_rst_frame_cnt", frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
